cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the CDB_WIDTH common-data-bus lanes among NUM_FU functional units (int ALU, mul/div,
//  branch, load/store). Each cycle it grants up to CDB_WIDTH requesting FUs in round-robin order.
//  It registers the granted results onto the CDB lanes, which feed RS wakeup, the PRF write and ROB completion.
// PARAMETERS
//  NUM_FU      4   number of requesting functional units (>= CDB_WIDTH)
//  CDB_WIDTH   2   number of broadcast lanes
//  ROB_IDX_W   5   ROB index width
//  PRF_IDX_W   6   physical register index width
//  ARF_IDX_W   5   architectural register index width
//  DATA_W      32  result data width
// PORTS
//  clk         in   1                    clock
//  rst         in   1                    synchronous active-high reset
//  flush       in   1                    backend flush (branch mispredict); kills arbitration this cycle
//  fu_valid    in   NUM_FU               per-FU result request
//  fu_ready    out  NUM_FU               per-FU grant; result consumed when fu_valid&fu_ready
//  fu_rob_id   in   NUM_FU*ROB_IDX_W     per-FU ROB index (FU i at [i*W +: W])
//  fu_rd_phy   in   NUM_FU*PRF_IDX_W     per-FU destination physical reg
//  fu_rd_arch  in   NUM_FU*ARF_IDX_W     per-FU destination arch reg
//  fu_rd_v     in   NUM_FU*DATA_W        per-FU result value
//  fu_regf_we  in   NUM_FU               per-FU register-write enable (0 for branches/stores without rd)
//  cdb_valid   out  CDB_WIDTH            lane valid, one-cycle pulse per broadcast
//  cdb_rob_id  out  CDB_WIDTH*ROB_IDX_W  lane ROB index
//  cdb_rd_phy  out  CDB_WIDTH*PRF_IDX_W  lane physical destination
//  cdb_rd_arch out  CDB_WIDTH*ARF_IDX_W  lane arch destination
//  cdb_rd_v    out  CDB_WIDTH*DATA_W     lane result value
//  cdb_regf_we out  CDB_WIDTH            lane register-write enable
// BEHAVIOUR
//  - State: rr_ptr ($clog2(NUM_FU) bits), the highest-priority FU index; registered CDB lane fields.
//  - Reset (rst=1 at posedge): rr_ptr=0, all cdb_* outputs 0. fu_ready is combinational and is 0
//    while rst=1. Reset mid-operation drops any in-flight grant; the FU keeps its valid and retries.
//  - Grant (combinational, cycle t): scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU. The first
//    CDB_WIDTH FUs with fu_valid=1 get fu_ready=1. The k-th grant in scan order goes to lane k.
//    Lanes fill from lane 0 upward with no holes.
//  - fu_ready[i] depends on fu_valid (ready-after-valid). FUs must not gate valid on ready.
//    An ungranted FU holds valid and payload stable until granted.
//  - Latency: a grant in cycle t drives the lane at t+1 with cdb_valid=1 for exactly one cycle.
//    A lane without a grant drives cdb_valid=0. Payload fields of an invalid lane are don't-care
//    (implementation zeroes them).
//  - rr_ptr update at end of cycle t: if >=1 grant, rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
//    With no grant, rr_ptr holds. Wrap-around from NUM_FU-1 to 0 is a normal part of the scan.
//  - Fairness: a continuously valid FU is granted within ceil(NUM_FU/CDB_WIDTH) cycles.
//  - Fewer requesters than lanes: every requester is granted the same cycle and the spare lanes stay invalid.
//  - flush=1 in cycle t: all fu_ready=0, every cdb_valid=0 at t+1, rr_ptr holds. Lanes already
//    broadcasting in cycle t are not affected (flush acts on the next registration only).
//  - rst has priority over flush.
//  - No combinational path from fu_* inputs to cdb_* outputs. There is exactly one register stage.
// TESTING (NUM_FU=4, CDB_WIDTH=2 unless noted)
//  1. Assert rst 2 cycles with fu_valid=4'b1111 -> fu_ready=0, cdb_valid=0, rr_ptr=0 after release.
//  2. rr_ptr=0, fu_valid=1111 held 2 cycles -> t+1: lane0=FU0, lane1=FU1; t+2: lane0=FU2, lane1=FU3; rr_ptr=0.
//  3. rr_ptr=0, only FU3 valid (rob_id=5'd9, value=32'hDEAD_BEEF) -> t+1: lane0 rob 9 / DEAD_BEEF,
//     cdb_valid=2'b01, rr_ptr=0.
//  4. rr_ptr=3, fu_valid=1011 -> fu_ready=1001, lane0=FU3, lane1=FU0, rr_ptr=1; next cycle FU1 on lane0.
//  5. fu_valid=1111 with flush=1 -> fu_ready=0000, cdb_valid=00 at t+1, rr_ptr unchanged.
//  6. fu_regf_we=0 for branch FU2 granted -> its lane shows cdb_regf_we=0, cdb_valid=1.
//     Random valid streams over 1000 cycles -> no FU waits more than 2 cycles; no duplicate or lost results.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing CDB_WIDTH broadcast lanes among NUM_FU functional units
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int ROB_IDX_W = 5,
    parameter int PRF_IDX_W = 6,
    parameter int ARF_IDX_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_FU-1:0]              fu_valid,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic [NUM_FU*ROB_IDX_W-1:0]    fu_rob_id,
    input  logic [NUM_FU*PRF_IDX_W-1:0]    fu_rd_phy,
    input  logic [NUM_FU*ARF_IDX_W-1:0]    fu_rd_arch,
    input  logic [NUM_FU*DATA_W-1:0]       fu_rd_v,
    input  logic [NUM_FU-1:0]              fu_regf_we,
    output logic [CDB_WIDTH-1:0]           cdb_valid,
    output logic [CDB_WIDTH*ROB_IDX_W-1:0] cdb_rob_id,
    output logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_rd_phy,
    output logic [CDB_WIDTH*ARF_IDX_W-1:0] cdb_rd_arch,
    output logic [CDB_WIDTH*DATA_W-1:0]    cdb_rd_v,
    output logic [CDB_WIDTH-1:0]           cdb_regf_we
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     next_ptr;
    logic [PTR_W-1:0]     lane_sel [CDB_WIDTH];
    logic [CDB_WIDTH-1:0] lane_hit;
    int                   grant_cnt;
    int                   scan_idx;

    // Scan from rr_ptr with wrap; the k-th valid FU found lands on lane k.
    always_comb begin
        fu_ready  = '0;
        lane_hit  = '0;
        next_ptr  = rr_ptr;
        grant_cnt = 0;
        scan_idx  = 0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            lane_sel[k] = '0;
        end
        if (!rst && !flush) begin
            for (int off = 0; off < NUM_FU; off++) begin
                scan_idx = int'(rr_ptr) + off;
                if (scan_idx >= NUM_FU) begin
                    scan_idx = scan_idx - NUM_FU;
                end
                if (fu_valid[scan_idx] && grant_cnt < CDB_WIDTH) begin
                    fu_ready[scan_idx]  = 1'b1;
                    lane_sel[grant_cnt] = PTR_W'(scan_idx);
                    lane_hit[grant_cnt] = 1'b1;
                    grant_cnt           = grant_cnt + 1;
                    next_ptr            = (scan_idx == NUM_FU - 1) ? '0 : PTR_W'(scan_idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cdb_valid   <= '0;
            cdb_rob_id  <= '0;
            cdb_rd_phy  <= '0;
            cdb_rd_arch <= '0;
            cdb_rd_v    <= '0;
            cdb_regf_we <= '0;
        end else begin
            rr_ptr <= next_ptr;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_valid[k] <= lane_hit[k];
                if (lane_hit[k]) begin
                    cdb_rob_id[k*ROB_IDX_W +: ROB_IDX_W]  <= fu_rob_id[int'(lane_sel[k])*ROB_IDX_W +: ROB_IDX_W];
                    cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W]  <= fu_rd_phy[int'(lane_sel[k])*PRF_IDX_W +: PRF_IDX_W];
                    cdb_rd_arch[k*ARF_IDX_W +: ARF_IDX_W] <= fu_rd_arch[int'(lane_sel[k])*ARF_IDX_W +: ARF_IDX_W];
                    cdb_rd_v[k*DATA_W +: DATA_W]          <= fu_rd_v[int'(lane_sel[k])*DATA_W +: DATA_W];
                    cdb_regf_we[k]                        <= fu_regf_we[lane_sel[k]];
                end else begin
                    cdb_rob_id[k*ROB_IDX_W +: ROB_IDX_W]  <= '0;
                    cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W]  <= '0;
                    cdb_rd_arch[k*ARF_IDX_W +: ARF_IDX_W] <= '0;
                    cdb_rd_v[k*DATA_W +: DATA_W]          <= '0;
                    cdb_regf_we[k]                        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of cdb_arbiter
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  fu_valid;
    logic [3:0]  fu_ready;
    logic [19:0] fu_rob_id;
    logic [23:0] fu_rd_phy;
    logic [19:0] fu_rd_arch;
    logic [127:0] fu_rd_v;
    logic [3:0]  fu_regf_we;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_rob_id;
    logic [11:0] cdb_rd_phy;
    logic [9:0]  cdb_rd_arch;
    logic [63:0] cdb_rd_v;
    logic [1:0]  cdb_regf_we;

    int errors = 0;
    int checks = 0;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rob_id(fu_rob_id), .fu_rd_phy(fu_rd_phy), .fu_rd_arch(fu_rd_arch),
        .fu_rd_v(fu_rd_v), .fu_regf_we(fu_regf_we),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rd_phy(cdb_rd_phy),
        .cdb_rd_arch(cdb_rd_arch), .cdb_rd_v(cdb_rd_v), .cdb_regf_we(cdb_regf_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [4:0] rob, input logic [31:0] val, input logic we);
        fu_rob_id[i*5 +: 5]  = rob;
        fu_rd_phy[i*6 +: 6]  = 6'(rob + 5'd10);
        fu_rd_arch[i*5 +: 5] = rob + 5'd3;
        fu_rd_v[i*32 +: 32]  = val;
        fu_regf_we[i]        = we;
    endtask

    function automatic logic [4:0] lane_rob(input int k);
        return cdb_rob_id[k*5 +: 5];
    endfunction

    function automatic logic [31:0] lane_v(input int k);
        return cdb_rd_v[k*32 +: 32];
    endfunction

    logic [3:0]  v, r, gm;
    logic [7:0]  seq [4];
    logic [31:0] pv  [4];
    int          wait_c [4];
    int          produced, received;

    // Lanes must carry exactly the FUs granted last cycle, each once, with their payload.
    task automatic check_lanes();
        int n;
        logic [7:0] f0, f1;
        n = $countones(gm);
        chk("rnd_valid", 64'(cdb_valid), (n == 0) ? 64'd0 : (n == 1) ? 64'd1 : 64'd3);
        for (int k = 0; k < 2; k++) begin
            if (k < n) begin
                f0 = lane_v(k)[31:24];
                chk("rnd_fu_granted", 64'(f0 < 8'd4 && gm[f0[1:0]]), 64'd1);
                chk("rnd_payload", 64'(lane_v(k)), 64'(pv[f0[1:0]]));
                received++;
            end
        end
        if (n == 2) begin
            f0 = lane_v(0)[31:24];
            f1 = lane_v(1)[31:24];
            chk("rnd_dup", 64'(f0 == f1), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; fu_valid = 4'b1111;
        fu_rob_id = '0; fu_rd_phy = '0; fu_rd_arch = '0; fu_rd_v = '0; fu_regf_we = '0;
        for (int i = 0; i < 4; i++) set_fu(i, 5'(i + 1), 32'h100 + 32'(i), 1'b1);
        set_fu(2, 5'd3, 32'h102, 1'b0);

        // reset held two cycles with all FUs requesting
        #1; chk("rst_ready0", 64'(fu_ready), 64'd0);
        step(); chk("rst_ready1", 64'(fu_ready), 64'd0);
        step(); chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_cdb_rob", 64'(cdb_rob_id), 64'd0);
        rst = 1'b0; fu_valid = 4'b1111;
        #1; chk("t2_ready_a", 64'(fu_ready), 64'b0011);
        step();
        chk("t2_valid_a", 64'(cdb_valid), 64'b11);
        chk("t2_lane0_a", 64'(lane_rob(0)), 64'd1);
        chk("t2_lane1_a", 64'(lane_rob(1)), 64'd2);
        #1; chk("t2_ready_b", 64'(fu_ready), 64'b1100);
        step();
        chk("t2_valid_b", 64'(cdb_valid), 64'b11);
        chk("t2_lane0_b", 64'(lane_rob(0)), 64'd3);
        chk("t2_lane1_b", 64'(lane_rob(1)), 64'd4);
        chk("t2_regf_we_b", 64'(cdb_regf_we), 64'b10);

        // single requester FU3 with rr_ptr=0
        fu_valid = 4'b1000;
        set_fu(3, 5'd9, 32'hDEAD_BEEF, 1'b1);
        #1; chk("t3_ready", 64'(fu_ready), 64'b1000);
        step();
        chk("t3_valid", 64'(cdb_valid), 64'b01);
        chk("t3_rob", 64'(lane_rob(0)), 64'd9);
        chk("t3_value", 64'(lane_v(0)), 64'hDEAD_BEEF);
        chk("t3_phy", 64'(cdb_rd_phy[5:0]), 64'd19);
        chk("t3_lane1_zero", 64'(lane_v(1)), 64'd0);
        set_fu(3, 5'd4, 32'h103, 1'b1);

        // rr_ptr wrapped back to 0: FU0 and FU2 (branch, no rd) win over FU3
        fu_valid = 4'b1101;
        #1; chk("t6_ready", 64'(fu_ready), 64'b0101);
        step();
        chk("t6_valid", 64'(cdb_valid), 64'b11);
        chk("t6_lane1_rob", 64'(lane_rob(1)), 64'd3);
        chk("t6_regf_we", 64'(cdb_regf_we), 64'b01);

        // rr_ptr=3 wrap-around scan
        fu_valid = 4'b1011;
        #1; chk("t4_ready", 64'(fu_ready), 64'b1001);
        step();
        chk("t4_lane0", 64'(lane_rob(0)), 64'd4);
        chk("t4_lane1", 64'(lane_rob(1)), 64'd1);
        fu_valid = 4'b0010;
        #1; chk("t4_ready_b", 64'(fu_ready), 64'b0010);
        step();
        chk("t4_valid_b", 64'(cdb_valid), 64'b01);
        chk("t4_lane0_b", 64'(lane_rob(0)), 64'd2);

        // flush kills arbitration and holds rr_ptr (=2)
        fu_valid = 4'b1111; flush = 1'b1;
        #1; chk("t5_ready", 64'(fu_ready), 64'd0);
        step();
        chk("t5_valid", 64'(cdb_valid), 64'd0);
        flush = 1'b0;
        #1; chk("t5_ready_held", 64'(fu_ready), 64'b1100);
        step();
        chk("t5_valid_b", 64'(cdb_valid), 64'b11);
        flush = 1'b1;
        #1; chk("t5_inflight", 64'(cdb_valid), 64'b11);
        chk("t5_inflight_rob", 64'(lane_rob(0)), 64'd3);
        step();
        chk("t5_valid_c", 64'(cdb_valid), 64'd0);

        // rst over flush, and reset mid-operation returns rr_ptr to 0
        flush = 1'b0;
        #1; chk("t1_ready_pre", 64'(fu_ready), 64'b0011);
        step();
        rst = 1'b1; flush = 1'b1;
        #1; chk("t1_ready_rst", 64'(fu_ready), 64'd0);
        step();
        chk("t1_cdb_rst", 64'(cdb_valid), 64'd0);
        rst = 1'b0; flush = 1'b0;
        #1; chk("t1_ready_post", 64'(fu_ready), 64'b0011);
        fu_valid = 4'b0000;
        step();
        step();

        // random request streams
        v = '0; gm = '0; produced = 0; received = 0;
        for (int i = 0; i < 4; i++) begin
            seq[i] = '0; pv[i] = '0; wait_c[i] = 0;
        end
        for (int c = 0; c < 1000; c++) begin
            check_lanes();
            if (c < 980) begin
                for (int i = 0; i < 4; i++) begin
                    if (!v[i] && $urandom_range(0, 1) == 1) begin
                        seq[i] = seq[i] + 8'd1;
                        v[i] = 1'b1;
                        produced++;
                        set_fu(i, seq[i][4:0], {8'(i), 16'h0, seq[i]}, seq[i][0]);
                    end
                end
            end
            fu_valid = v;
            #1;
            r = fu_ready;
            chk("rnd_ready_mask", 64'(r & ~v), 64'd0);
            chk("rnd_ready_cnt", 64'($countones(r)), 64'(($countones(v) > 2) ? 2 : $countones(v)));
            for (int i = 0; i < 4; i++) begin
                if (v[i] && !r[i]) begin
                    wait_c[i]++;
                    chk("rnd_wait", 64'(wait_c[i] > 1), 64'd0);
                end
                if (r[i]) begin
                    pv[i] = {8'(i), 16'h0, seq[i]};
                    wait_c[i] = 0;
                end
            end
            gm = r;
            step();
            v = v & ~gm;
        end
        check_lanes();
        chk("rnd_lost", 64'(received), 64'(produced));
        chk("rnd_drained", 64'(v), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
